// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file operation sequencer: default widths,
// FSM state encoding and the EXEC timeout length.
package rf_seq_pkg;

   localparam int DATA_W_DEF  = 4;
   localparam int ADDR_W_DEF  = 2;
   localparam int TIMEOUT_CYC = 15;
   localparam int TIMER_W     = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_CAPTURE,
      ST_EXEC,
      ST_WRITE
   } state_t;

endpackage

// File: rtl/rf_seq_timer.sv
// EXEC-phase watchdog: counts cycles while run is high and flags the last
// permitted cycle; only instantiated when RF_SEQ_TIMEOUT_EN is defined.
module rf_seq_timer
   import rf_seq_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic expired
);

   logic [TIMER_W-1:0] cnt;

   // Holding the count at zero outside EXEC gives a fresh count on every entry.
   always_ff @(posedge clk) begin
      if (rst || !run) cnt <= '0;
      else             cnt <= cnt + 1'b1;
   end

   assign expired = run && (cnt == TIMER_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/rf_sequencer.sv
// Sequences one operation: read two registers, hand operands to the execute
// unit, optionally write the result back. Optional EXEC timeout: RF_SEQ_TIMEOUT_EN.
module rf_sequencer
   import rf_seq_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_rs1,
   input  logic [ADDR_W-1:0] req_rs2,
   input  logic [ADDR_W-1:0] req_rd,
   input  logic              req_wb,
   output logic [ADDR_W-1:0] rf_read_reg1,
   output logic [ADDR_W-1:0] rf_read_reg2,
   output logic [ADDR_W-1:0] rf_write_reg,
   output logic              rf_rw,
   output logic [DATA_W-1:0] rf_write_data,
   input  logic [DATA_W-1:0] rf_data_out1,
   input  logic [DATA_W-1:0] rf_data_out2,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic              op_valid,
   input  logic              res_valid,
   input  logic [DATA_W-1:0] res_data,
   output logic              done,
   output logic              err
);

   state_t            state, state_n;
   logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
   logic              wb_q;
   logic [DATA_W-1:0] op_a_q, op_b_q, res_q;
   logic              done_q, done_n;
   logic              timeout;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         done_q <= 1'b0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         rd_q   <= '0;
         wb_q   <= 1'b0;
         op_a_q <= '0;
         op_b_q <= '0;
         res_q  <= '0;
      end else begin
         state  <= state_n;
         done_q <= done_n;
         if (state == ST_IDLE && req_valid) begin
            rs1_q <= req_rs1;
            rs2_q <= req_rs2;
            rd_q  <= req_rd;
            wb_q  <= req_wb;
         end
         if (state == ST_CAPTURE) begin
            op_a_q <= rf_data_out1;
            op_b_q <= rf_data_out2;
         end
         if (state == ST_EXEC && res_valid) res_q <= res_data;
      end
   end

   // NOTE: defaults first so no path through the case leaves a variable
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_n = state;
      done_n  = 1'b0;
      case (state)
         ST_IDLE:    if (req_valid) state_n = ST_READ;
         ST_READ:    state_n = ST_CAPTURE;
         ST_CAPTURE: state_n = ST_EXEC;
         ST_EXEC: begin
            if (res_valid) begin
               if (wb_q) begin
                  state_n = ST_WRITE;
               end else begin
                  state_n = ST_IDLE;
                  done_n  = 1'b1;
               end
            end else if (timeout) begin
               state_n = ST_IDLE;
            end
         end
         ST_WRITE: begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
         end
         default:    state_n = ST_IDLE;
      endcase
   end

`ifdef RF_SEQ_TIMEOUT_EN
   logic err_q;

   rf_seq_timer u_timer (
      .clk     (clk),
      .rst     (rst),
      .run     (state == ST_EXEC),
      .expired (timeout)
   );

   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= (state == ST_EXEC) && !res_valid && timeout;
   end

   assign err = err_q && !rst;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   // Outputs are gated by rst so a reset landing mid-WRITE never issues the write.
   assign req_ready     = (state == ST_IDLE) && !rst;
   assign rf_rw         = rst || (state != ST_WRITE);
   assign rf_read_reg1  = rst ? '0 : rs1_q;
   assign rf_read_reg2  = rst ? '0 : rs2_q;
   assign rf_write_reg  = rst ? '0 : rd_q;
   assign rf_write_data = (!rst && state == ST_WRITE) ? res_q : '0;
   assign op_valid      = !rst && (state == ST_EXEC);
   assign op_a          = rst ? '0 : op_a_q;
   assign op_b          = rst ? '0 : op_b_q;
   assign done          = done_q && !rst;

endmodule

// File: tb/tb_rf_sequencer.sv
// Self-checking bench for rf_sequencer: directed and random operations against a
// register-array reference model; timeout branch follows RF_SEQ_TIMEOUT_EN.
module tb_rf_sequencer;

   localparam int DW = 4;
   localparam int AW = 2;
   localparam int TIMEOUT_LIMIT = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_rs1 = '0, req_rs2 = '0, req_rd = '0;
   logic          req_wb = 1'b0;
   logic [AW-1:0] rf_read_reg1, rf_read_reg2, rf_write_reg;
   logic          rf_rw;
   logic [DW-1:0] rf_write_data;
   logic [DW-1:0] rf_data_out1 = '0, rf_data_out2 = '0;
   logic [DW-1:0] op_a, op_b;
   logic          op_valid;
   logic          res_valid = 1'b0;
   logic [DW-1:0] res_data = '0;
   logic          done, err;

   rf_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_rs1       (req_rs1),
      .req_rs2       (req_rs2),
      .req_rd        (req_rd),
      .req_wb        (req_wb),
      .rf_read_reg1  (rf_read_reg1),
      .rf_read_reg2  (rf_read_reg2),
      .rf_write_reg  (rf_write_reg),
      .rf_rw         (rf_rw),
      .rf_write_data (rf_write_data),
      .rf_data_out1  (rf_data_out1),
      .rf_data_out2  (rf_data_out2),
      .op_a          (op_a),
      .op_b          (op_b),
      .op_valid      (op_valid),
      .res_valid     (res_valid),
      .res_data      (res_data),
      .done          (done),
      .err           (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Register-file environment: registered read data, write when rf_rw is low.
   logic [DW-1:0] rf_mem [4] = '{default: '0};
   always @(posedge clk) begin
      if (rf_rw) begin
         rf_data_out1 <= rf_mem[rf_read_reg1];
         rf_data_out2 <= rf_mem[rf_read_reg2];
      end else begin
         rf_mem[rf_write_reg] <= rf_write_data;
      end
   end

   logic [DW-1:0] exp_rf [4];
   int total = 0, bad = 0;
   int wr_cnt = 0, done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
   logic [AW-1:0] wr_reg = '0;
   logic [DW-1:0] wr_data = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (rf_rw === 1'b0) begin
         wr_cnt++;
         wr_reg  = rf_write_reg;
         wr_data = rf_write_data;
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (err === 1'b1) begin
         err_cnt++;
         err_cyc = cyc;
      end
   endtask

   task automatic drive_req(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                            input logic [AW-1:0] rd, input logic wb);
      chk("ready_before_req", req_ready, 1);
      req_valid = 1'b1;
      req_rs1   = rs1;
      req_rs2   = rs2;
      req_rd    = rd;
      req_wb    = wb;
   endtask

   task automatic junk_req();
      req_valid = 1'($urandom_range(0, 1));
      req_rs1   = 2'($urandom_range(0, 3));
      req_rs2   = 2'($urandom_range(0, 3));
      req_rd    = 2'($urandom_range(0, 3));
      req_wb    = 1'($urandom_range(0, 1));
   endtask

   // One full operation; expectations come from the model array and the
   // latency rule accept->done = 4 + res delay + wb.
   task automatic run_op(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic wb,
                         input logic [DW-1:0] res, input int delay);
      int a, w0, d0, lat;
      logic [DW-1:0] ea, eb;
      ea  = exp_rf[rs1];
      eb  = exp_rf[rs2];
      lat = 4 + delay + int'(wb);
      a   = cyc;
      w0  = wr_cnt;
      d0  = done_cnt;
      drive_req(rs1, rs2, rd, wb);
      for (int k = 1; k <= lat; k++) begin
         tick();
         if (k < lat) junk_req();
         if (k == 3 + delay) begin
            res_valid = 1'b1;
            res_data  = res;
         end else begin
            res_valid = 1'b0;
            res_data  = 4'($urandom_range(0, 15));
         end
         if (k == 2) chk("op_valid_early", op_valid, 0);
         if (k >= 3 && k <= 3 + delay) begin
            chk("op_valid_exec", op_valid, 1);
            chk("op_a", op_a, ea);
            chk("op_b", op_b, eb);
         end
      end
      req_valid = 1'b0;
      res_valid = 1'b0;
      chk("done_count", done_cnt - d0, 1);
      chk("done_latency", done_cyc - a, lat);
      chk("write_count", wr_cnt - w0, int'(wb));
      if (wb) begin
         chk("write_reg", wr_reg, rd);
         chk("write_data", wr_data, res);
         exp_rf[rd] = res;
      end
      chk("rf_contents", rf_mem[rd], exp_rf[rd]);
   endtask

   // Raise rst just after the edge that starts cycle accept+hit.
   task automatic run_abort(input logic [AW-1:0] rd, input logic [DW-1:0] res,
                            input int delay, input int hit);
      int w0, d0;
      w0 = wr_cnt;
      d0 = done_cnt;
      drive_req(2'd0, 2'd1, rd, 1'b1);
      for (int k = 1; k < hit; k++) begin
         tick();
         req_valid = 1'b0;
         res_valid = (k == 3 + delay);
         res_data  = res;
      end
      @(posedge clk);
      #1;
      rst       = 1'b1;
      res_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("abort_rf_rw", rf_rw, 1);
         chk("abort_op_valid", op_valid, 0);
      end
      rst = 1'b0;
      tick();
      chk("abort_ready", req_ready, 1);
      chk("abort_no_write", wr_cnt - w0, 0);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_rf_kept", rf_mem[rd], exp_rf[rd]);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) exp_rf[i] = '0;

      // Reset held five cycles.
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("rst_rf_rw", rf_rw, 1);
         chk("rst_op_valid", op_valid, 0);
         chk("rst_done", done, 0);
         chk("rst_err", err, 0);
         chk("rst_ready", req_ready, 0);
         chk("rst_op_a", op_a, 0);
      end
      rst = 1'b0;
      tick();
      chk("ready_after_rst", req_ready, 1);

      // Write-back, chained read, no write-back, rd aliasing a source.
      run_op(2'd0, 2'd0, 2'd1, 1'b1, 4'd5, 0);
      run_op(2'd1, 2'd1, 2'd3, 1'b1, 4'd15, 0);
      run_op(2'd2, 2'd3, 2'd0, 1'b0, 4'd9, 0);
      run_op(2'd3, 2'd1, 2'd3, 1'b1, 4'd7, 2);

      // Reset while in EXEC, then while in WRITE.
      run_abort(2'd2, 4'd11, 5, 4);
      run_abort(2'd2, 4'd12, 0, 4);

      for (int n = 0; n < 24; n++) begin
         run_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
      end

      // EXEC stall with res_valid held low.
      begin
         int a, w0, d0, e0;
         a  = cyc;
         w0 = wr_cnt;
         d0 = done_cnt;
         e0 = err_cnt;
         drive_req(2'd1, 2'd2, 2'd0, 1'b1);
`ifdef RF_SEQ_TIMEOUT_EN
         for (int k = 1; k <= 3 + TIMEOUT_LIMIT + 3; k++) begin
            tick();
            req_valid = 1'b0;
            if (k >= 3 && k < 3 + TIMEOUT_LIMIT) chk("stall_op_valid", op_valid, 1);
            if (k == 3 + TIMEOUT_LIMIT) chk("timeout_op_valid_drop", op_valid, 0);
         end
         chk("timeout_err_count", err_cnt - e0, 1);
         chk("timeout_err_cycle", err_cyc - a, 3 + TIMEOUT_LIMIT);
         chk("timeout_ready", req_ready, 1);
`else
         for (int k = 1; k <= 110; k++) begin
            tick();
            req_valid = 1'b0;
            if (k >= 3) chk("stall_op_valid", op_valid, 1);
         end
         chk("stall_no_err", err_cnt - e0, 0);
         rst = 1'b1;
         tick();
         rst = 1'b0;
         tick();
`endif
         chk("stall_no_write", wr_cnt - w0, 0);
         chk("stall_no_done", done_cnt - d0, 0);
      end

      // Sequencer still usable after the stall.
      run_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'd2, 1'b1, 4'd6, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
